fetch_queue: RTL and testbench

Instruction buffer between the fetch stage and decode. Replaces the plain IF/D pipeline register with a small FIFO of fetch packets: instruction, PC, PC+4 and prediction bit. Fetch can run ahead while decode stalls, and the buffer backpressures the PC when full. Every entry is discarded on a branch redirect from execute.

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetch_queue_if.sv | 32 +++
 rtl/fetch_queue_storage.sv | 24 ++
 rtl/fetch_queue.sv | 77 +++++++
 tb/tb_fetch_queue.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction buffer.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        predict_taken;
  } fetch_packet_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side signals of the fetch queue.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic          Valid_F;
  logic [31:0]   Instr_F;
  logic [31:0]   PC_F;
  logic [31:0]   PC_Plus_4_F;
  logic          Predict_Taken_F;
  logic          Flush;
  logic          Stall_D;
  logic          PC_En;
  logic          Valid_D;
  logic [31:0]   Instr_D;
  logic [31:0]   PC_D;
  logic [31:0]   PC_Plus_4_D;
  logic          Predict_Taken_D;
  logic [CW-1:0] Count;

  modport master (
    output Valid_F, Instr_F, PC_F, PC_Plus_4_F, Predict_Taken_F, Flush, Stall_D,
    input  PC_En, Valid_D, Instr_D, PC_D, PC_Plus_4_D, Predict_Taken_D, Count
  );

  modport slave (
    input  Valid_F, Instr_F, PC_F, PC_Plus_4_F, Predict_Taken_F, Flush, Stall_D,
    output PC_En, Valid_D, Instr_D, PC_D, PC_Plus_4_D, Predict_Taken_D, Count
  );

endinterface

// File: rtl/fetch_queue_storage.sv
// Packet array: synchronous write, asynchronous read (distributed RAM style).
module fetch_queue_storage
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_packet_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_packet_t rdata
);

  fetch_packet_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch packets between fetch and decode, emptied on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_queue_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  fetch_packet_t wr_pkt;
  fetch_packet_t rd_pkt;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // Full is judged on registered count only, so Stall_D never reaches PC_En.
  assign push  = bus.Valid_F && !full && !bus.Flush && !RST;
  assign pop   = !empty && !bus.Stall_D && !bus.Flush;

  assign wr_pkt = '{instr:         bus.Instr_F,
                    pc:            bus.PC_F,
                    pc_plus_4:     bus.PC_Plus_4_F,
                    predict_taken: bus.Predict_Taken_F};

  always_ff @(posedge CLK) begin
    if (RST || bus.Flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  fetch_queue_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .clk   (CLK),
    .we    (push),
    .waddr (tail),
    .wdata (wr_pkt),
    .raddr (head),
    .rdata (rd_pkt)
  );

  always_comb begin
    bus.PC_En           = !full;
    bus.Valid_D         = !empty;
    bus.Count           = count;
    bus.Instr_D         = NOP_INSTR;
    bus.PC_D            = '0;
    bus.PC_Plus_4_D     = '0;
    bus.Predict_Taken_D = 1'b0;
    if (!empty) begin
      bus.Instr_D         = rd_pkt.instr;
      bus.PC_D            = rd_pkt.pc;
      bus.PC_Plus_4_D     = rd_pkt.pc_plus_4;
      bus.Predict_Taken_D = rd_pkt.predict_taken;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, then random traffic vs a queue model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  fetch_packet_t model_q[$];

  typedef struct {
    logic        rst;
    logic        v;
    logic        fl;
    logic        st;
    logic [31:0] pc;
    logic        ev;
    logic [31:0] epc;
    int unsigned ecnt;
    logic        een;
  } vec_t;

  vec_t vecs[17];

  function automatic logic [31:0] f_instr(input logic [31:0] pc);
    logic [11:0] imm;
    imm = pc[11:0] + 12'd5;
    return {imm, 20'h00093};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic pt, input logic fl, input logic st);
    RST                 = rst;
    bus.Valid_F         = v;
    bus.PC_F            = pc;
    bus.PC_Plus_4_F     = pc + 32'd4;
    bus.Instr_F         = instr;
    bus.Predict_Taken_F = pt;
    bus.Flush           = fl;
    bus.Stall_D         = st;
  endtask

  // Queue semantics of the buffer, applied with the inputs present at the coming edge.
  task automatic model_step();
    bit do_pop;
    bit do_push;
    if (RST || bus.Flush) begin
      model_q.delete();
    end else begin
      do_pop  = (model_q.size() != 0) && !bus.Stall_D;
      do_push = bus.Valid_F && (model_q.size() != DEPTH);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back('{instr: bus.Instr_F, pc: bus.PC_F,
                                       pc_plus_4: bus.PC_Plus_4_F,
                                       predict_taken: bus.Predict_Taken_F});
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_model();
    fetch_packet_t h;
    h = '{instr: NOP_INSTR, pc: '0, pc_plus_4: '0, predict_taken: 1'b0};
    if (model_q.size() != 0) h = model_q[0];
    chk("rnd_valid", 32'(bus.Valid_D), 32'(model_q.size() != 0));
    chk("rnd_count", 32'(bus.Count), model_q.size());
    chk("rnd_pc_en", 32'(bus.PC_En), 32'(model_q.size() != DEPTH));
    chk("rnd_instr", bus.Instr_D, h.instr);
    chk("rnd_pc", bus.PC_D, h.pc);
    chk("rnd_pc4", bus.PC_Plus_4_D, h.pc_plus_4);
    chk("rnd_pt", 32'(bus.Predict_Taken_D), 32'(h.predict_taken));
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] pc_ctr;
    logic        r_rst, r_v, r_fl, r_st;

    //           rst v  fl st pc     ev epc    cnt en
    vecs[0]  = '{1, 0, 0, 0, 32'h00, 0, 32'h00, 0, 1};
    vecs[1]  = '{0, 1, 0, 0, 32'h00, 1, 32'h00, 1, 1};
    vecs[2]  = '{0, 0, 0, 0, 32'h00, 0, 32'h00, 0, 1};
    vecs[3]  = '{0, 1, 0, 1, 32'h00, 1, 32'h00, 1, 1};
    vecs[4]  = '{0, 1, 0, 1, 32'h04, 1, 32'h00, 2, 1};
    vecs[5]  = '{0, 1, 0, 1, 32'h08, 1, 32'h00, 3, 1};
    vecs[6]  = '{0, 1, 0, 1, 32'h0c, 1, 32'h00, 4, 0};
    vecs[7]  = '{0, 1, 0, 1, 32'h10, 1, 32'h00, 4, 0};
    vecs[8]  = '{0, 1, 0, 0, 32'h10, 1, 32'h04, 3, 1};
    vecs[9]  = '{0, 0, 0, 0, 32'h00, 1, 32'h08, 2, 1};
    vecs[10] = '{0, 1, 0, 0, 32'h10, 1, 32'h0c, 2, 1};
    vecs[11] = '{0, 1, 0, 1, 32'h14, 1, 32'h0c, 3, 1};
    vecs[12] = '{0, 1, 1, 0, 32'h40, 0, 32'h00, 0, 1};
    vecs[13] = '{0, 1, 0, 1, 32'h44, 1, 32'h44, 1, 1};
    vecs[14] = '{0, 1, 0, 1, 32'h48, 1, 32'h44, 2, 1};
    vecs[15] = '{1, 1, 0, 0, 32'h4c, 0, 32'h00, 0, 1};
    vecs[16] = '{0, 0, 0, 1, 32'h00, 0, 32'h00, 0, 1};

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].pc, f_instr(vecs[i].pc), vecs[i].pc[3],
            vecs[i].fl, vecs[i].st);
      tick();
      exp_pc = vecs[i].ev ? vecs[i].epc : 32'h0;
      chk($sformatf("vec%0d_valid", i), 32'(bus.Valid_D), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_count", i), 32'(bus.Count), vecs[i].ecnt);
      chk($sformatf("vec%0d_pc_en", i), 32'(bus.PC_En), 32'(vecs[i].een));
      chk($sformatf("vec%0d_instr", i), bus.Instr_D, vecs[i].ev ? f_instr(vecs[i].epc) : NOP_INSTR);
      chk($sformatf("vec%0d_pc", i), bus.PC_D, exp_pc);
      chk($sformatf("vec%0d_pc4", i), bus.PC_Plus_4_D, vecs[i].ev ? exp_pc + 32'd4 : 32'h0);
      chk($sformatf("vec%0d_pt", i), 32'(bus.Predict_Taken_D), 32'(vecs[i].ev & exp_pc[3]));
    end

    // Back-to-back unstalled stream: behaves as a single pipeline register.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 32'h100 + 32'(i) * 4, f_instr(32'h100 + 32'(i) * 4), 1'b1, 1'b0, 1'b0);
      tick();
      chk("stream_pc", bus.PC_D, 32'h100 + 32'(i) * 4);
      chk("stream_count", 32'(bus.Count), 32'd1);
    end

    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check_model();

    pc_ctr = 32'h200;
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 99) < 2);
      r_fl  = ($urandom_range(0, 99) < 5);
      r_v   = ($urandom_range(0, 99) < 70);
      r_st  = ($urandom_range(0, 99) < 40);
      drive(r_rst, r_v, pc_ctr, $urandom, 1'($urandom), r_fl, r_st);
      pc_ctr = pc_ctr + 32'd4;
      tick();
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
